mem_latency_slave: RTL and testbench

MEM_LATENCY_SLAVE -- requirements
Module: mem_latency_slave

---
 rtl/mem_latency_slave_if.sv | 33 +++
 rtl/mem_latency_slave.sv | 192 +++++++++++++++++++
 tb/tb_mem_latency_slave.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_latency_slave_if.sv
// Read/write request bus between the cache/direct-path mux and the latency memory slave.
interface mem_latency_slave_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 128
);

  localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] raddr;
  logic                  ren;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  wen;
  logic [DATA_WIDTH-1:0] wdata;
  logic [MASK_WIDTH-1:0] wmask;
  logic                  wvalid;
  logic [31:0]           rd_count;
  logic [31:0]           wr_count;

  // Requester side: drives requests, observes completions and statistics.
  modport master (
    output raddr, ren, waddr, wen, wdata, wmask,
    input  rvalid, rdata, wvalid, rd_count, wr_count
  );

  // Memory side: accepts requests, returns completions and statistics.
  modport slave (
    input  raddr, ren, waddr, wen, wdata, wmask,
    output rvalid, rdata, wvalid, rd_count, wr_count
  );

endinterface

// File: rtl/mem_latency_slave.sv
// Single-port line memory with fixed, programmable access latency.
// One access in flight; writes win over reads when both are requested.
module mem_latency_slave #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned LATENCY    = 4
) (
  input  logic            clk,
  input  logic            rstn,
  mem_latency_slave_if.slave bus
);

  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned OFFS_W = $clog2(BYTES);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
  // With a one-cycle latency the access completes on the accepting edge itself.
  localparam bit SINGLE = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rd_acc_c, wr_acc_c, rd_done_c, wr_done_c;

  logic [IDX_W-1:0]      rd_idx_q, wr_idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BYTES-1:0]      wmask_q;

  logic [IDX_W-1:0]      rd_idx_c, wr_idx_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [BYTES-1:0]      wmask_c;

  logic                  rvalid_q, wvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [31:0]           rd_count_q, wr_count_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Address bits outside the line index are intentionally ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.raddr, bus.waddr};

  // State and latency counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, counter and accept/complete strobes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rd_acc_c  = 1'b0;
    wr_acc_c  = 1'b0;
    rd_done_c = 1'b0;
    wr_done_c = 1'b0;
    case (state)
      IDLE: begin
        if (bus.wen) begin
          wr_acc_c = 1'b1;
          if (SINGLE) begin
            wr_done_c = 1'b1;
          end else begin
            state_nxt = WR_WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end else if (bus.ren) begin
          rd_acc_c = 1'b1;
          if (SINGLE) begin
            rd_done_c = 1'b1;
          end else begin
            state_nxt = RD_WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      RD_WAIT: begin
        if (!bus.ren) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          rd_done_c = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_LAST;
        end
      end
      WR_WAIT: begin
        if (!bus.wen) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          wr_done_c = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_LAST;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Completing access uses live inputs at one-cycle latency, latched ones otherwise.
  always_comb begin
    rd_idx_c = rd_idx_q;
    wr_idx_c = wr_idx_q;
    wdata_c  = wdata_q;
    wmask_c  = wmask_q;
    if (SINGLE) begin
      rd_idx_c = bus.raddr[OFFS_W +: IDX_W];
      wr_idx_c = bus.waddr[OFFS_W +: IDX_W];
      wdata_c  = bus.wdata;
      wmask_c  = bus.wmask;
    end
  end

  // Request capture on acceptance; later bus changes are ignored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
    end else begin
      if (wr_acc_c) begin
        wr_idx_q <= bus.waddr[OFFS_W +: IDX_W];
        wdata_q  <= bus.wdata;
        wmask_q  <= bus.wmask;
      end
      if (rd_acc_c) begin
        rd_idx_q <= bus.raddr[OFFS_W +: IDX_W];
      end
    end
  end

  // Byte-masked line write; array contents survive reset, no write while in reset.
  always_ff @(posedge clk) begin
    if (wr_done_c && rstn) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wmask_c[i]) begin
          mem[wr_idx_c][8*i +: 8] <= wdata_c[8*i +: 8];
        end
      end
    end
  end

  // Completion pulses, read data and statistics counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid_q   <= 1'b0;
      wvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rvalid_q <= rd_done_c;
      wvalid_q <= wr_done_c;
      if (rd_done_c) begin
        rdata_q    <= mem[rd_idx_c];
        rd_count_q <= rd_count_q + 32'd1;
      end
      if (wr_done_c) begin
        wr_count_q <= wr_count_q + 32'd1;
      end
    end
  end

  assign bus.rvalid   = rvalid_q;
  assign bus.wvalid   = wvalid_q;
  assign bus.rdata    = rdata_q;
  assign bus.rd_count = rd_count_q;
  assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_mem_latency_slave.sv
// Scoreboard bench: two slaves (latency 4 and latency 1) against a line-array model.
module tb_mem_latency_slave;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 128;
  localparam int unsigned MW = DW / 8;

  typedef struct {
    int             dut;
    bit             is_wr;
    logic [DW-1:0]  data;
    int             due;
  } exp_t;

  logic       clk;
  logic [1:0] rstn_d;

  mem_latency_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus4 ();
  mem_latency_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  mem_latency_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4096), .LATENCY(4)) dut4 (
    .clk(clk), .rstn(rstn_d[0]), .bus(bus4)
  );
  mem_latency_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4096), .LATENCY(1)) dut1 (
    .clk(clk), .rstn(rstn_d[1]), .bus(bus1)
  );

  logic          ren_d [2];
  logic          wen_d [2];
  logic [AW-1:0] raddr_d [2];
  logic [AW-1:0] waddr_d [2];
  logic [DW-1:0] wdata_d [2];
  logic [MW-1:0] wmask_d [2];

  assign bus4.ren = ren_d[0];   assign bus1.ren = ren_d[1];
  assign bus4.wen = wen_d[0];   assign bus1.wen = wen_d[1];
  assign bus4.raddr = raddr_d[0]; assign bus1.raddr = raddr_d[1];
  assign bus4.waddr = waddr_d[0]; assign bus1.waddr = waddr_d[1];
  assign bus4.wdata = wdata_d[0]; assign bus1.wdata = wdata_d[1];
  assign bus4.wmask = wmask_d[0]; assign bus1.wmask = wmask_d[1];

  logic [1:0]    rv, wv;
  logic [DW-1:0] rd_s [2];
  logic [31:0]   rc_s [2];
  logic [31:0]   wc_s [2];

  assign rv[0] = bus4.rvalid;   assign rv[1] = bus1.rvalid;
  assign wv[0] = bus4.wvalid;   assign wv[1] = bus1.wvalid;
  assign rd_s[0] = bus4.rdata;  assign rd_s[1] = bus1.rdata;
  assign rc_s[0] = bus4.rd_count; assign rc_s[1] = bus1.rd_count;
  assign wc_s[0] = bus4.wr_count; assign wc_s[1] = bus1.wr_count;

  exp_t          expq [$];
  logic [DW-1:0] mref [int];
  int            mrd [2];
  int            mwr [2];
  logic [DW-1:0] last_rd [2];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat(int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int key(int d, logic [AW-1:0] a);
    return d * 4096 + int'(a[15:4]);
  endfunction

  function automatic logic [AW-1:0] mkaddr(int idx);
    logic [AW-1:0] a;
    a = {$urandom, $urandom};
    a[15:4] = 12'(idx);
    return a;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(int k, logic [DW-1:0] data, logic [MW-1:0] m);
    logic [DW-1:0] line;
    line = mref.exists(k) ? mref[k] : '0;
    for (int i = 0; i < MW; i++)
      if (m[i]) line[8*i +: 8] = data[8*i +: 8];
    mref[k] = line;
  endtask

  task automatic push_write(int d, logic [AW-1:0] a, logic [DW-1:0] data, logic [MW-1:0] m, int due);
    exp_t e;
    model_write(key(d, a), data, m);
    e.dut = d; e.is_wr = 1'b1; e.data = data; e.due = due;
    expq.push_back(e);
    mwr[d]++;
  endtask

  task automatic push_read(int d, logic [AW-1:0] a, int due);
    exp_t e;
    e.dut = d; e.is_wr = 1'b0; e.data = mref[key(d, a)]; e.due = due;
    last_rd[d] = e.data;
    expq.push_back(e);
    mrd[d]++;
  endtask

  task automatic scramble(int d);
    raddr_d[d] = {$urandom, $urandom};
    waddr_d[d] = {$urandom, $urandom};
    wdata_d[d] = rnd_data();
    wmask_d[d] = MW'($urandom);
  endtask

  // One full access; bus fields are scrambled while waiting to prove they were latched.
  task automatic do_xfer(int d, bit is_wr, logic [AW-1:0] a, logic [DW-1:0] data, logic [MW-1:0] m);
    bit seen = 1'b0;
    if (is_wr) begin
      waddr_d[d] = a; wdata_d[d] = data; wmask_d[d] = m; wen_d[d] = 1'b1;
      push_write(d, a, data, m, cyc + lat(d));
    end else begin
      raddr_d[d] = a; ren_d[d] = 1'b1;
      push_read(d, a, cyc + lat(d));
    end
    for (int i = 0; i < 300; i++) begin
      step();
      if (is_wr ? wv[d] : rv[d]) begin
        seen = 1'b1;
        break;
      end
      scramble(d);
    end
    ren_d[d] = 1'b0;
    wen_d[d] = 1'b0;
    if (!seen) chk("xfer_timeout", DW'(is_wr ? wv[d] : rv[d]), DW'(1));
  endtask

  // Request dropped part-way through the wait: nothing may complete.
  task automatic do_abort(int d, bit is_wr, logic [AW-1:0] a, int extra);
    if (is_wr) begin
      waddr_d[d] = a; wdata_d[d] = rnd_data(); wmask_d[d] = '1; wen_d[d] = 1'b1;
    end else begin
      raddr_d[d] = a; ren_d[d] = 1'b1;
    end
    step();
    repeat (extra) begin
      step();
      scramble(d);
    end
    ren_d[d] = 1'b0;
    wen_d[d] = 1'b0;
    step();
    step();
    chk("abort_rdata_hold", rd_s[d], last_rd[d]);
    chk("abort_rd_count", DW'(rc_s[d]), DW'(mrd[d]));
    chk("abort_wr_count", DW'(wc_s[d]), DW'(mwr[d]));
  endtask

  // Read and write raised together: write is served first, read follows.
  task automatic do_both(int d, logic [AW-1:0] wa, logic [DW-1:0] wd, logic [MW-1:0] wm, logic [AW-1:0] ra);
    bit seen = 1'b0;
    push_write(d, wa, wd, wm, cyc + lat(d));
    push_read(d, ra, cyc + 2 * lat(d));
    waddr_d[d] = wa; wdata_d[d] = wd; wmask_d[d] = wm; wen_d[d] = 1'b1;
    raddr_d[d] = ra; ren_d[d] = 1'b1;
    for (int i = 0; i < 600; i++) begin
      step();
      if (wv[d]) wen_d[d] = 1'b0;
      if (rv[d]) begin
        seen = 1'b1;
        break;
      end
    end
    ren_d[d] = 1'b0;
    wen_d[d] = 1'b0;
    if (!seen) chk("both_timeout", DW'(rv[d]), DW'(1));
  endtask

  // Read held high across completions, address advanced at each one.
  task automatic do_b2b(int d, logic [AW-1:0] a0, logic [AW-1:0] a1, logic [AW-1:0] a2);
    logic [AW-1:0] a [3];
    int got = 0;
    a[0] = a0; a[1] = a1; a[2] = a2;
    raddr_d[d] = a[0]; ren_d[d] = 1'b1;
    push_read(d, a[0], cyc + lat(d));
    for (int i = 0; i < 100 && got < 3; i++) begin
      step();
      if (rv[d]) begin
        got++;
        if (got < 3) begin
          raddr_d[d] = a[got];
          push_read(d, a[got], cyc + lat(d));
        end
      end
    end
    ren_d[d] = 1'b0;
    if (got < 3) chk("b2b_timeout", DW'(got), DW'(3));
  endtask

  task automatic rand_phase(int d, int n);
    int lines [6];
    int li, lj, op;
    for (int i = 0; i < 6; i++) begin
      lines[i] = $urandom_range(0, 4095);
      do_xfer(d, 1'b1, mkaddr(lines[i]), rnd_data(), '1);
    end
    for (int j = 0; j < n; j++) begin
      op = $urandom_range(0, 3);
      li = lines[$urandom_range(0, 5)];
      lj = lines[$urandom_range(0, 5)];
      case (op)
        0: do_xfer(d, 1'b1, mkaddr(li), rnd_data(), MW'($urandom));
        1: do_xfer(d, 1'b0, mkaddr(li), '0, '0);
        2: do_both(d, mkaddr(li), rnd_data(), MW'($urandom), mkaddr(lj));
        default: begin
          if (lat(d) > 1) do_abort(d, $urandom_range(0, 1) == 1, mkaddr(li), $urandom_range(0, lat(d) - 2));
          else do_xfer(d, 1'b0, mkaddr(li), '0, '0);
        end
      endcase
      if ($urandom_range(0, 1) == 1) step();
    end
  endtask

  // Monitor: every completion pulse must match the oldest expectation for that slave.
  always @(posedge clk) begin : monitor
    int   idx [$];
    exp_t e;
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rv[d] || wv[d]) begin
        chk($sformatf("dual_valid_d%0d", d), DW'(rv[d] & wv[d]), '0);
        idx = expq.find_first_index with (item.dut == d);
        if (idx.size() == 0) begin
          chk($sformatf("unexpected_valid_d%0d", d), DW'({rv[d], wv[d]}), '0);
        end else begin
          e = expq[idx[0]];
          expq.delete(idx[0]);
          chk($sformatf("valid_kind_d%0d", d), DW'(wv[d]), DW'(e.is_wr));
          chk($sformatf("valid_cycle_d%0d", d), DW'(cyc), DW'(e.due));
          if (!e.is_wr) chk($sformatf("rdata_d%0d", d), rd_s[d], e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] d0;
    clk = 1'b0;
    rstn_d = 2'b00;
    for (int d = 0; d < 2; d++) begin
      ren_d[d] = 1'b0; wen_d[d] = 1'b0;
      raddr_d[d] = '0; waddr_d[d] = '0; wdata_d[d] = '0; wmask_d[d] = '0;
      mrd[d] = 0; mwr[d] = 0; last_rd[d] = '0;
    end
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      chk("reset_rvalid", DW'(rv[d]), '0);
      chk("reset_wvalid", DW'(wv[d]), '0);
      chk("reset_rdata", rd_s[d], '0);
      chk("reset_rd_count", DW'(rc_s[d]), '0);
      chk("reset_wr_count", DW'(wc_s[d]), '0);
    end
    rstn_d = 2'b11;

    // Full write then read of line 0x40, first request on the first edge after reset.
    do_xfer(0, 1'b1, 64'h40, {16{8'hAA}}, '1);
    do_xfer(0, 1'b0, 64'h40, '0, '0);
    chk("basic_rdata", rd_s[0], {16{8'hAA}});
    chk("basic_wr_count", DW'(wc_s[0]), DW'(1));
    chk("basic_rd_count", DW'(rc_s[0]), DW'(1));

    // Byte-masked write over the same line.
    do_xfer(0, 1'b1, 64'h40, {16{8'h55}}, 16'h00FF);
    do_xfer(0, 1'b0, 64'h40, '0, '0);
    chk("partial_rdata", rd_s[0], {{8{8'hAA}}, {8{8'h55}}});

    // Simultaneous request to the same line.
    do_both(0, 64'h80, 128'h1234, '1, 64'h80);
    chk("both_rdata", rd_s[0], 128'h1234);

    // Read dropped after two wait cycles, then a normal read.
    do_abort(0, 1'b0, 64'h80, 2);
    do_xfer(0, 1'b0, 64'h40, '0, '0);

    // Reset in the middle of a pending write.
    d0 = {4{32'hC0C0_1234}};
    do_xfer(0, 1'b1, 64'hC0, d0, '1);
    waddr_d[0] = 64'hC0; wdata_d[0] = ~d0; wmask_d[0] = '1; wen_d[0] = 1'b1;
    step();
    step();
    #2 rstn_d[0] = 1'b0;
    #1 wen_d[0] = 1'b0;
    chk("rst_rvalid", DW'(rv[0]), '0);
    chk("rst_wvalid", DW'(wv[0]), '0);
    chk("rst_rdata", rd_s[0], '0);
    chk("rst_rd_count", DW'(rc_s[0]), '0);
    chk("rst_wr_count", DW'(wc_s[0]), '0);
    mrd[0] = 0; mwr[0] = 0; last_rd[0] = '0;
    step();
    step();
    rstn_d[0] = 1'b1;
    do_xfer(0, 1'b0, 64'hC0, '0, '0);
    chk("rst_mem_kept", rd_s[0], d0);
    chk("rst_post_wr_count", DW'(wc_s[0]), '0);

    // Latency 1: back-to-back reads and upper-address aliasing.
    do_xfer(1, 1'b1, 64'h10000, 128'hA11A5, '1);
    do_xfer(1, 1'b1, 64'h10, 128'h0B0B, '1);
    do_xfer(1, 1'b1, 64'h20, 128'h0C0C, '1);
    do_b2b(1, 64'h0, 64'h10, 64'h20);
    chk("b2b_rd_count", DW'(rc_s[1]), DW'(3));
    do_xfer(1, 1'b0, 64'h0, '0, '0);
    chk("alias_rdata", rd_s[1], 128'hA11A5);

    rand_phase(0, 60);
    rand_phase(1, 60);

    repeat (6) step();
    chk("queue_empty", DW'(expq.size()), '0);
    for (int d = 0; d < 2; d++) begin
      chk("final_rd_count", DW'(rc_s[d]), DW'(mrd[d]));
      chk("final_wr_count", DW'(wc_s[d]), DW'(mwr[d]));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
